// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and saturating-arithmetic helpers for the branch predictor
package bp_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Step a value of the given width one unit up or down, clamping at all-ones and at zero.
  // Callers zero-extend into 64 bits and cast the result back to their own width.
  function automatic logic [63:0] sat_step(input logic [63:0] value,
                                           input int unsigned width,
                                           input logic        up);
    logic [63:0] top;
    top = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    if (up) sat_step = (value >= top) ? top : value + 64'd1;
    else    sat_step = (value == 64'd0) ? 64'd0 : value - 64'd1;
  endfunction

  // Weakly-not-taken: the largest value whose MSB is still clear.
  function automatic logic [63:0] ctr_reset_value(input int unsigned width);
    ctr_reset_value = (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// rtl/bp_pht.sv - pattern history table: saturating counters, combinational read, one write port
module bp_pht
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic                  wr_taken
);

  localparam int                   ENTRIES  = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'(ctr_reset_value(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  // Read returns the stored value, so a same-cycle write is not visible until the next cycle.
  assign rd_ctr = ctr_q[rd_index];

  // Train the addressed counter toward the resolved outcome; reset puts every entry at weak-not-taken.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else if (wr_en) begin
      ctr_q[wr_index] <= CTR_BITS'(sat_step(64'(ctr_q[wr_index]), CTR_BITS, wr_taken));
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal/gshare predictor with mispredict flush and performance counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = 64,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int MODE       = 0,
  parameter int STAT_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  lookup_valid,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  predict_taken,
  output logic [INDEX_BITS-1:0] predict_index,
  input  logic                  resolve_valid,
  input  logic [INDEX_BITS-1:0] resolve_index,
  input  logic                  resolve_taken,
  input  logic                  resolve_predicted,
  output logic                  flush_ID_EX,
  output logic [STAT_BITS-1:0]  branch_count,
  output logic [STAT_BITS-1:0]  mispredict_count
);

  logic [INDEX_BITS-1:0] ghr;
  logic [INDEX_BITS-1:0] pc_index;
  logic [CTR_BITS-1:0]   lookup_ctr;
  logic                  unused_pc_bits;

  // Instructions are word aligned, so the index starts above the two byte-offset bits.
  assign pc_index       = lookup_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0]};

  // In bimodal mode ghr is tied to zero so the XOR collapses to the plain PC index.
  assign predict_index = pc_index ^ ghr;

  generate
    if (MODE == MODE_GSHARE) begin : g_ghr
      // History shifts in resolved outcomes only, so wrong-path fetches never pollute it.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)            ghr <= '0;
        else if (resolve_valid) ghr <= INDEX_BITS'({ghr, resolve_taken});
      end
    end else begin : g_no_ghr
      assign ghr = '0;
    end
  endgenerate

  bp_pht #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS)
  ) u_pht (
    .clk      (clk),
    .arst_n   (arst_n),
    .rd_index (predict_index),
    .rd_ctr   (lookup_ctr),
    .wr_en    (resolve_valid),
    .wr_index (resolve_index),
    .wr_taken (resolve_taken)
  );

  // Outputs are forced quiet while reset is held so the pipeline sees no stray prediction or flush.
  assign predict_taken = arst_n & lookup_valid & lookup_ctr[CTR_BITS-1];
  assign flush_ID_EX   = arst_n & resolve_valid & (resolve_taken ^ resolve_predicted);

  // Performance counters stick at all-ones rather than wrapping back to a misleading small value.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (resolve_valid)
        branch_count <= STAT_BITS'(sat_step(64'(branch_count), STAT_BITS, 1'b1));
      if (flush_ID_EX)
        mispredict_count <= STAT_BITS'(sat_step(64'(mispredict_count), STAT_BITS, 1'b1));
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for bimodal and gshare predictor instances
module tb_branch_predictor;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        b_lookup_valid, b_predict_taken, b_resolve_valid, b_resolve_taken, b_resolve_predicted, b_flush;
  logic [63:0] b_lookup_pc;
  logic [5:0]  b_predict_index, b_resolve_index;
  logic [31:0] b_branch_count, b_mispredict_count;

  logic        g_lookup_valid, g_predict_taken, g_resolve_valid, g_resolve_taken, g_resolve_predicted, g_flush;
  logic [31:0] g_lookup_pc;
  logic [3:0]  g_predict_index, g_resolve_index;
  logic [2:0]  g_branch_count, g_mispredict_count;

  branch_predictor #(.PC_WIDTH(64), .INDEX_BITS(6), .CTR_BITS(2), .MODE(0), .STAT_BITS(32)) u_bimodal (
    .clk(clk), .arst_n(arst_n),
    .lookup_valid(b_lookup_valid), .lookup_pc(b_lookup_pc),
    .predict_taken(b_predict_taken), .predict_index(b_predict_index),
    .resolve_valid(b_resolve_valid), .resolve_index(b_resolve_index),
    .resolve_taken(b_resolve_taken), .resolve_predicted(b_resolve_predicted),
    .flush_ID_EX(b_flush), .branch_count(b_branch_count), .mispredict_count(b_mispredict_count)
  );

  branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(4), .CTR_BITS(2), .MODE(1), .STAT_BITS(3)) u_gshare (
    .clk(clk), .arst_n(arst_n),
    .lookup_valid(g_lookup_valid), .lookup_pc(g_lookup_pc),
    .predict_taken(g_predict_taken), .predict_index(g_predict_index),
    .resolve_valid(g_resolve_valid), .resolve_index(g_resolve_index),
    .resolve_taken(g_resolve_taken), .resolve_predicted(g_resolve_predicted),
    .flush_ID_EX(g_flush), .branch_count(g_branch_count), .mispredict_count(g_mispredict_count)
  );

  typedef struct {
    string       name;
    int          cyc;
    bit          g;
    logic        pred;
    logic [5:0]  idx;
    logic        flush;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic push(input string nm, input bit g, input logic p, input logic [5:0] idx,
                      input logic f, input logic [31:0] bc, input logic [31:0] mc);
    exp_t x;
    x.name = nm; x.cyc = cyc; x.g = g; x.pred = p; x.idx = idx; x.flush = f; x.bc = bc; x.mc = mc;
    sb.push_back(x);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic b_set(input logic lv, input logic [63:0] pc, input logic rv, input logic [5:0] ri,
                       input logic rt, input logic rp);
    b_lookup_valid = lv; b_lookup_pc = pc; b_resolve_valid = rv;
    b_resolve_index = ri; b_resolve_taken = rt; b_resolve_predicted = rp;
  endtask

  task automatic g_set(input logic lv, input logic [31:0] pc, input logic rv, input logic [3:0] ri,
                       input logic rt, input logic rp);
    g_lookup_valid = lv; g_lookup_pc = pc; g_resolve_valid = rv;
    g_resolve_index = ri; g_resolve_taken = rt; g_resolve_predicted = rp;
  endtask

  // Monitor: compare every expectation due this cycle against the settled combinational outputs.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s: expectation from cycle %0d not checked, now cycle %0d", e.name, e.cyc, cyc);
      end else if (e.g) begin
        chk({e.name, ".pred"},  {31'd0, g_predict_taken}, {31'd0, e.pred});
        chk({e.name, ".idx"},   {28'd0, g_predict_index}, {26'd0, e.idx});
        chk({e.name, ".flush"}, {31'd0, g_flush},         {31'd0, e.flush});
        chk({e.name, ".bc"},    {29'd0, g_branch_count},  e.bc);
        chk({e.name, ".mc"},    {29'd0, g_mispredict_count}, e.mc);
      end else begin
        chk({e.name, ".pred"},  {31'd0, b_predict_taken}, {31'd0, e.pred});
        chk({e.name, ".idx"},   {26'd0, b_predict_index}, {26'd0, e.idx});
        chk({e.name, ".flush"}, {31'd0, b_flush},         {31'd0, e.flush});
        chk({e.name, ".bc"},    b_branch_count,           e.bc);
        chk({e.name, ".mc"},    b_mispredict_count,       e.mc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    exp_t left;
    arst_n = 1'b0;
    b_set(0, 64'h0, 0, 6'd0, 0, 0);
    g_set(0, 32'h0, 0, 4'd0, 0, 0);
    repeat (2) step();
    arst_n = 1'b1;

    // Post-reset lookups: weak-not-taken everywhere, stats zero.
    step(); b_set(1, 64'h14, 0, 6'd0, 0, 0); g_set(1, 32'h0, 0, 4'd0, 0, 0);
    push("b_reset", 0, 0, 6'd5, 0, 0, 0);
    push("g_reset", 1, 0, 6'd0, 0, 0, 0);
    g_set(0, 32'h0, 0, 4'd0, 0, 0);

    // Four resolves, three mismatches (index 20).
    step(); b_set(1, 64'h14, 1, 6'd20, 1, 0); push("m1", 0, 0, 6'd5, 1, 0, 0);
    step(); b_set(1, 64'h14, 1, 6'd20, 0, 0); push("m2", 0, 0, 6'd5, 0, 1, 1);
    step(); b_set(1, 64'h14, 1, 6'd20, 0, 1); push("m3", 0, 0, 6'd5, 1, 2, 1);
    step(); b_set(1, 64'h14, 1, 6'd20, 1, 0); push("m4", 0, 0, 6'd5, 1, 3, 2);

    // Train index 5: two taken, three more taken (saturate), then not-taken steps.
    step(); b_set(1, 64'h14, 1, 6'd5, 1, 0); push("tr_a", 0, 0, 6'd5, 1, 4, 3);
    step(); b_set(1, 64'h14, 1, 6'd5, 1, 1); push("tr_b", 0, 1, 6'd5, 0, 5, 4);
    step(); b_set(1, 64'h14, 1, 6'd5, 1, 1); push("tr_c", 0, 1, 6'd5, 0, 6, 4);
    step(); b_set(1, 64'h14, 1, 6'd5, 1, 1); push("tr_d", 0, 1, 6'd5, 0, 7, 4);
    step(); b_set(1, 64'h14, 1, 6'd5, 1, 1); push("tr_e", 0, 1, 6'd5, 0, 8, 4);
    step(); b_set(1, 64'h14, 1, 6'd5, 0, 1); push("tr_f", 0, 1, 6'd5, 1, 9, 4);
    step(); b_set(1, 64'h14, 0, 6'd0, 0, 0); push("ctr2", 0, 1, 6'd5, 0, 10, 5);
    step(); b_set(1, 64'h14, 1, 6'd5, 0, 1); push("tr_h", 0, 1, 6'd5, 1, 10, 5);
    step(); b_set(1, 64'h14, 0, 6'd0, 0, 0); push("ctr1", 0, 0, 6'd5, 0, 11, 6);

    // Same-cycle lookup and update at index 9: no bypass.
    step(); b_set(1, 64'h24, 1, 6'd9, 1, 0); push("hazard_same", 0, 0, 6'd9, 1, 11, 6);
    step(); b_set(1, 64'h24, 0, 6'd0, 0, 0); push("hazard_next", 0, 1, 6'd9, 0, 12, 7);

    // gshare history: T, NT, T, T -> 4'b1011; same-cycle lookups use pre-update ghr.
    step(); b_set(0, 64'h0, 0, 6'd0, 0, 0); push("b_idle", 0, 0, 6'd0, 0, 12, 7);
    g_set(1, 32'h0, 1, 4'd0, 1, 1); push("g1", 1, 0, 6'd0, 0, 0, 0);
    step(); g_set(1, 32'h0, 1, 4'd0, 0, 0); push("g2", 1, 0, 6'd1, 0, 1, 0);
    step(); g_set(1, 32'h0, 1, 4'd0, 1, 1); push("g3", 1, 0, 6'd2, 0, 2, 0);
    step(); g_set(1, 32'h0, 1, 4'd0, 1, 1); push("g4", 1, 0, 6'd5, 0, 3, 0);
    step(); g_set(1, 32'h0, 1, 4'd3, 1, 0); push("g_hist", 1, 0, 6'd11, 1, 4, 0);

    // Drive 3-bit stats into saturation with mispredicting taken resolves to index 3.
    for (int i = 6; i <= 13; i++) begin
      step(); g_set(0, 32'h0, 1, 4'd3, 1, 0);
      if (i == 8)  push("g_stats7_3", 1, 0, 6'd15, 1, 7, 3);
      if (i == 12) push("g_stats7_7", 1, 0, 6'd15, 1, 7, 7);
    end
    step(); g_set(1, 32'h30, 0, 4'd0, 0, 0); push("g_sat", 1, 1, 6'd3, 0, 7, 7);

    // Asynchronous reset mid-cycle with mismatching resolves presented.
    step(); b_set(1, 64'h14, 1, 6'd5, 1, 0); g_set(1, 32'h30, 1, 4'd3, 1, 0);
    #1 arst_n = 1'b0;
    push("rst_b", 0, 0, 6'd5, 0, 0, 0);
    push("rst_g", 1, 0, 6'd12, 0, 0, 0);
    step(); b_set(0, 64'h0, 0, 6'd0, 0, 0); g_set(0, 32'h0, 0, 4'd0, 0, 0);
    step(); arst_n = 1'b1;
    g_set(1, 32'h0C, 0, 4'd0, 0, 0); push("post_rst_g", 1, 0, 6'd3, 0, 0, 0);
    b_set(1, 64'h14, 0, 6'd0, 0, 0); push("post_rst_b", 0, 0, 6'd5, 0, 0, 0);

    repeat (3) step();
    while (sb.size() > 0) begin
      left = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: expectation never checked", left.name);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
